sram_rw_arbiter: RTL

SRAM_RW_ARBITER -- requirements
Module: sram_rw_arbiter

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_rr_arb2.sv | 64 ++++++
 rtl/sram_rw_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared geometry defaults and request-tracking types for the SRAM read/write arbiter.
package sram_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_WMASKS = 4;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
    logic    we;
  } trk_entry_t;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, registered last-winner pointer.
module sram_rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rstb,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_any,
  output logic       gnt_id
);

  req_id_e last_q;
  req_id_e last_d;
  req_id_e win_s;

  // Grant a lone requester directly; on a tie favour whoever did not win last.
  always_comb begin
    gnt    = 2'b00;
    win_s  = REQ_A;
    last_d = last_q;
    case (req)
      2'b01: begin
        gnt   = 2'b01;
        win_s = REQ_A;
      end
      2'b10: begin
        gnt   = 2'b10;
        win_s = REQ_B;
      end
      2'b11: begin
        if (last_q == REQ_B) begin
          gnt   = 2'b01;
          win_s = REQ_A;
        end else begin
          gnt   = 2'b10;
          win_s = REQ_B;
        end
      end
      default: begin
        gnt   = 2'b00;
        win_s = REQ_A;
      end
    endcase
    if (gnt != 2'b00) begin
      last_d = win_s;
    end else begin
      last_d = last_q;
    end
  end

  assign gnt_any = |gnt;
  assign gnt_id  = win_s;

  // Pointer resets to B so A takes the first tie after reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram_rw_arbiter.sv
// Shares the RW port of a dual-port SRAM macro between requesters A and B and
// drives the read-only port for requester C, with fixed two-cycle completion latency.
module sram_rw_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*NUM_WMASKS-1:0] req_wmask,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]   rd_rsp_data,
  output logic                    csb0,
  output logic                    web0,
  output logic [NUM_WMASKS-1:0]   wmask0,
  output logic [ADDR_WIDTH-1:0]   addr0,
  output logic [DATA_WIDTH-1:0]   din0,
  input  logic [DATA_WIDTH-1:0]   dout0,
  output logic                    csb1,
  output logic [ADDR_WIDTH-1:0]   addr1,
  input  logic [DATA_WIDTH-1:0]   dout1
);

  logic [1:0]            gnt_s;
  logic                  gnt_any_s;
  logic                  gnt_id_s;
  logic                  sel_we_s;
  logic [NUM_WMASKS-1:0] sel_wmask_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic                  rd_acc_s;

  logic                  csb0_q, csb0_d, web0_q, web0_d;
  logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic                  csb1_q, csb1_d;
  trk_entry_t            trk0_q, trk0_d, trk1_q, trk1_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rdp0_q, rdp0_d, rdp1_q, rdp1_d;
  logic                  rd_rsp_valid_q, rd_rsp_valid_d;
  logic [DATA_WIDTH-1:0] rd_rsp_data_q, rd_rsp_data_d;

  sram_rr_arb2 u_rr (
    .clk     (clk),
    .rstb    (rstb),
    .req     (req_valid),
    .gnt     (gnt_s),
    .gnt_any (gnt_any_s),
    .gnt_id  (gnt_id_s)
  );

  // Steer the winning requester's fields toward port 0.
  always_comb begin
    if (gnt_id_s) begin
      sel_we_s    = req_we[1];
      sel_wmask_s = req_wmask[2*NUM_WMASKS-1:NUM_WMASKS];
      sel_addr_s  = req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
      sel_wdata_s = req_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
    end else begin
      sel_we_s    = req_we[0];
      sel_wmask_s = req_wmask[NUM_WMASKS-1:0];
      sel_addr_s  = req_addr[ADDR_WIDTH-1:0];
      sel_wdata_s = req_wdata[DATA_WIDTH-1:0];
    end
  end

  // C is held off while a same-address write is being issued, so port 1 never races the write.
  assign rd_acc_s  = rd_valid & rstb & ~(gnt_any_s & sel_we_s & (sel_addr_s == rd_addr));
  assign req_ready = gnt_s & {2{rstb}};
  assign rd_ready  = rd_acc_s;

  // Next state for both macro ports and the two-stage completion pipes.
  always_comb begin
    wmask0_d = wmask0_q;
    addr0_d  = addr0_q;
    din0_d   = din0_q;
    if (gnt_any_s) begin
      csb0_d   = 1'b0;
      web0_d   = ~sel_we_s;
      wmask0_d = sel_wmask_s;
      addr0_d  = sel_addr_s;
      din0_d   = sel_wdata_s;
    end else begin
      csb0_d = 1'b1;
      web0_d = 1'b1;
    end
    trk0_d.valid = gnt_any_s;
    trk0_d.id    = req_id_e'(gnt_id_s);
    trk0_d.we    = sel_we_s;
    trk1_d       = trk0_q;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = rsp_rdata_q;
    if (trk1_q.valid) begin
      if (trk1_q.id == REQ_B) begin
        rsp_valid_d = 2'b10;
      end else begin
        rsp_valid_d = 2'b01;
      end
      if (!trk1_q.we) begin
        rsp_rdata_d = dout0;
      end else begin
        rsp_rdata_d = rsp_rdata_q;
      end
    end else begin
      rsp_valid_d = 2'b00;
    end
    csb1_d = ~rd_acc_s;
    if (rd_acc_s) begin
      addr1_d = rd_addr;
    end else begin
      addr1_d = addr1_q;
    end
    rdp0_d         = rd_acc_s;
    rdp1_d         = rdp0_q;
    rd_rsp_valid_d = rdp1_q;
    if (rdp1_q) begin
      rd_rsp_data_d = dout1;
    end else begin
      rd_rsp_data_d = rd_rsp_data_q;
    end
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      csb0_q         <= 1'b1;
      web0_q         <= 1'b1;
      wmask0_q       <= '0;
      addr0_q        <= '0;
      din0_q         <= '0;
      csb1_q         <= 1'b1;
      addr1_q        <= '0;
      trk0_q         <= '0;
      trk1_q         <= '0;
      rsp_valid_q    <= 2'b00;
      rsp_rdata_q    <= '0;
      rdp0_q         <= 1'b0;
      rdp1_q         <= 1'b0;
      rd_rsp_valid_q <= 1'b0;
      rd_rsp_data_q  <= '0;
    end else begin
      csb0_q         <= csb0_d;
      web0_q         <= web0_d;
      wmask0_q       <= wmask0_d;
      addr0_q        <= addr0_d;
      din0_q         <= din0_d;
      csb1_q         <= csb1_d;
      addr1_q        <= addr1_d;
      trk0_q         <= trk0_d;
      trk1_q         <= trk1_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rdp0_q         <= rdp0_d;
      rdp1_q         <= rdp1_d;
      rd_rsp_valid_q <= rd_rsp_valid_d;
      rd_rsp_data_q  <= rd_rsp_data_d;
    end
  end

  assign csb0         = csb0_q;
  assign web0         = web0_q;
  assign wmask0       = wmask0_q;
  assign addr0        = addr0_q;
  assign din0         = din0_q;
  assign csb1         = csb1_q;
  assign addr1        = addr1_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rd_rsp_valid = rd_rsp_valid_q;
  assign rd_rsp_data  = rd_rsp_data_q;

endmodule
